// File: rtl/sram_rw_port_ctrl.sv
// Generic synchronous FIFO with occupancy count; storage resets to zero so out_dat is 0 after reset.
// Latency: a push is visible on out_vld/out_dat the cycle after it is written.
// Backpressure: holds head data while out_vld && !out_rdy; caller must not push when full.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pop;

    assign out_vld = (cnt_q != '0);
    assign out_dat = mem_q[rd_ptr_q];
    assign count   = cnt_q;
    assign pop     = out_vld && out_rdy;

    // Storage, pointers and count; simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (in_vld) begin
                mem_q[wr_ptr_q] <= in_dat;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({in_vld, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// Initiator-side controller for a single-port masked SRAM (RW0 port); zero-fills the whole array after reset.
// Latency: writes commit at the accepting edge; read data is presented 2 cycles after acceptance.
// Backpressure: 2-entry response buffer; reads stall via req_ready once buffered + in-flight reads reach 2, writes never stall in RUN.
module sram_rw_port_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 10,
    parameter int LANE_W = 30
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LANES*LANE_W-1:0] req_wdata,
    input  logic [LANES-1:0]        req_wmask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [LANES*LANE_W-1:0] resp_rdata,
    output logic                    init_done,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_en,
    output logic                    mem_wmode,
    output logic [LANES-1:0]        mem_wmask,
    output logic [LANES*LANE_W-1:0] mem_wdata,
    input  logic [LANES*LANE_W-1:0] mem_rdata
);
    localparam int DATA_W = LANES * LANE_W;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] init_cnt_q;
    logic              init_done_q;
    logic              rd_pend_q;
    logic [1:0]        rbuf_cnt;
    logic              resp_pop;
    logic [2:0]        occ;
    logic              rd_credit;
    logic              accept;

    // Reads in flight (pending + buffered) minus the response leaving this cycle.
    // Counting this cycle's pop lets a full buffer accept a read while it drains.
    assign resp_pop  = resp_valid && resp_ready;
    assign occ       = {1'b0, rbuf_cnt} + {2'b00, rd_pend_q} - {2'b00, resp_pop};
    assign rd_credit = (occ < 3'd2);
    assign accept    = req_valid && req_ready;
    assign init_done = init_done_q;

    // Next state and port drive; everything is forced to zero while reset is held
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        if (!reset) begin
            case (state_q)
                ST_INIT: begin
                    mem_en    = 1'b1;
                    mem_wmode = 1'b1;
                    mem_wmask = '1;
                    mem_addr  = init_cnt_q;
                    if (&init_cnt_q) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    req_ready = req_write || rd_credit;
                    if (req_valid && (req_write || rd_credit)) begin
                        mem_en    = 1'b1;
                        mem_wmode = req_write;
                        mem_addr  = req_addr;
                        mem_wmask = req_write ? req_wmask : '0;
                        mem_wdata = req_write ? req_wdata : '0;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // State register, zero-fill address counter and sticky completion flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                init_cnt_q <= init_cnt_q + ADDR_W'(1);
                if (&init_cnt_q) begin
                    init_done_q <= 1'b1;
                end
            end
        end
    end

    // A read issued this cycle has macro data valid next cycle; flag it for capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= accept && !req_write;
        end
    end

    // Response buffer: captures macro read data at the end of the pending cycle,
    // which is the same edge a following write commits, so that write is not seen
    fifo #(
        .WIDTH (DATA_W),
        .DEPTH (2)
    ) u_rbuf (
        .clock   (clock),
        .reset   (reset),
        .in_vld  (rd_pend_q),
        .in_dat  (mem_rdata),
        .out_vld (resp_valid),
        .out_rdy (resp_ready),
        .out_dat (resp_rdata),
        .count   (rbuf_cnt)
    );
endmodule

// File: doc/sram_rw_port_ctrl.md
Name: sram_rw_port_ctrl

Overview:
Initiator-side controller for a single-port masked SRAM macro with an RW0-style port: 1024 x 300 bits, 10 lanes of 30 bits, one-cycle registered read latency. It converts valid/ready read and write requests into port cycles and returns read data through a 2-entry response buffer that absorbs backpressure. After every reset it zero-fills the array before accepting any request. It sits between a cache/TLB data pipeline and the memory macro.

Parameters:
ADDR_W, 10, address width; DEPTH = 2^ADDR_W entries
LANES, 10, number of write-mask lanes
LANE_W, 30, bits per lane; DATA_W = LANES*LANE_W = 300

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
req_wmask  in  LANES  per-lane write enable
resp_valid  out  1  read response valid
resp_ready  in  1  consumer accepts response
resp_rdata  out  DATA_W  read response data
init_done  out  1  zero-fill complete; sticky until reset
mem_addr  out  ADDR_W  to macro RW0_addr
mem_en  out  1  to macro RW0_en
mem_wmode  out  1  to macro RW0_wmode
mem_wmask  out  LANES  to macro RW0_wmask
mem_wdata  out  DATA_W  to macro RW0_wdata
mem_rdata  in  DATA_W  from macro RW0_rdata; valid the cycle after a read

Behaviour:
- Reset values: req_ready 0, resp_valid 0, resp_rdata 0, init_done 0, mem_en 0, mem_wmode 0, mem_addr/mem_wmask/mem_wdata 0; init counter 0; buffer empty; pending-read flag 0.
- States: INIT, RUN. Reset forces INIT.
- INIT: each cycle drives mem_en=1, mem_wmode=1, mem_wmask=all ones, mem_wdata=0, mem_addr=counter; counter increments. Cycle with counter=DEPTH-1 is the last write; next cycle state=RUN and init_done=1. Exactly DEPTH init writes; req_ready=0 throughout.
- RUN: mem_* are combinational from the request. When valid&&ready: mem_en=1, mem_wmode=req_write, mem_addr=req_addr, mem_wdata=req_wdata, mem_wmask=req_wmask. mem_wmask/mem_wdata are 0 for reads. With no accepted request, mem_en=0 and all other mem_* are 0.
- Read pipeline: a read accepted in cycle T sets the pending flag for T+1. At the end of T+1, mem_rdata is pushed into the 2-entry FIFO. resp_valid is asserted from T+2, so read latency is 2 cycles.
- Credits: occ = fifo_count + pending - (resp_valid&&resp_ready).
- Reads are ready when occ < 2.
- Writes are always ready in RUN. Writes consume no credit.
- req_ready = RUN && (req_write || occ<2). The combinational path from resp_ready to req_ready is intended.
- Sustained throughput is 1 request/cycle with resp_ready=1.
- Responses return in request order. resp_rdata is held stable while resp_valid && !resp_ready.
- Ordering: a write to address X in the cycle after a read of X does not affect that read. Capture happens at the same edge the write commits, so the read returns the old value.
- wmask=0 write: still issues a port cycle, memory unchanged, accepted normally.
- Simultaneous push and pop: fifo_count unchanged, data order preserved.
- Reset mid-operation (INIT or RUN): immediate return to reset values. Pending read and buffered responses are discarded. INIT restarts from address 0.

Test Plan:
- Release reset, hold req_valid=1 -> exactly 1024 writes (mem_en=1, wmode=1, wmask=0x3FF, wdata=0, addr 0..1023); init_done and req_ready rise in the cycle after addr 1023. A read of addr 1023 then returns 0.
- Write addr 5, data lanes i=0x1000+i, mask 0x3FF; then write addr 5, lane0=0x3FFFFFFF, mask 0x001; read addr 5 -> lane0=0x3FFFFFFF, lanes1..9=0x1001..0x1009, resp_valid 2 cycles after acceptance.
- resp_ready=1, 8 back-to-back reads of addrs 0..7 (pre-written 100+a) -> req_ready never drops; responses 100..107 in order on consecutive cycles.
- resp_ready=0, 3 reads issued -> first 2 accepted, third sees req_ready=0 while writes are still accepted. Raising resp_ready -> third read accepted; all 3 responses delivered in order, with resp_rdata stable while stalled.
- Write addr 9=0xAA..., read addr 9, then write addr 9=0x55... in the next cycle -> response is 0xAA...; a subsequent read returns 0x55....
- Assert reset at init cycle 500 and also during RUN with 2 buffered responses -> all outputs 0 immediately; after release, init restarts at addr 0 and the old responses never appear.
